if_id_queue: RTL

- Decoupling instruction queue between the fetch stage and the decode stage.
- Buffers fetched {instruction, PC, prediction} beats so a decode/hazard stall does not freeze fetch immediately.
- Drains in order to decode with a valid/ready handshake.
- Flushed on IF_flush or branch mispredict so no wrong-path instruction reaches decode.

---
 rtl/if_id_queue.sv | 66 ++++++
 1 files changed

// File: rtl/if_id_queue.sv
// if_id_queue: in-order fetch-to-decode FIFO with first-word fall-through and synchronous flush.
// Define IFQ_STATS_EN to add the flush_drop_count and full_stall_count statistics outputs.
module if_id_queue #(
    parameter int          DEPTH    = 4,
    parameter int          PTR_W    = 2,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instruction,
    input  logic [31:0]      in_pc,
    input  logic             in_prediction,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instruction,
    output logic [31:0]      out_pc,
    output logic             out_prediction,
`ifdef IFQ_STATS_EN
    output logic [15:0]      flush_drop_count,
    output logic [15:0]      full_stall_count,
`endif
    output logic [PTR_W:0]   count
);
    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);
    logic [64:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             push, pop;
    assign in_ready        = count != FULL;
    assign out_valid       = count != '0;
    assign push            = in_valid & in_ready;
    assign pop             = out_valid & out_ready;
    // Bubble values when empty so stale RAM never leaks to decode.
    assign out_instruction = out_valid ? mem[rd_ptr][31:0]  : NOP_WORD;
    assign out_pc          = out_valid ? mem[rd_ptr][63:32] : 32'h0;
    assign out_prediction  = out_valid & mem[rd_ptr][64];
    always_ff @(posedge clock)
        if (push & ~flush & ~reset) mem[wr_ptr] <= {in_prediction, in_pc, in_instruction};
    always_ff @(posedge clock) begin
        if (reset | flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end
    end
`ifdef IFQ_STATS_EN
    logic [16:0] drop_sum;
    assign drop_sum = {1'b0, flush_drop_count} + 17'(count) + 17'(in_valid);
    always_ff @(posedge clock) begin
        if (reset) begin
            flush_drop_count <= '0;
            full_stall_count <= '0;
        end else begin
            if (flush) flush_drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            if (in_valid & ~in_ready & (full_stall_count != 16'hFFFF))
                full_stall_count <= full_stall_count + 1'b1;
        end
    end
`endif
endmodule
